// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Purpose : Shared types and constants for the sequential restoring divider.
//           Holds the FSM state encoding, the default operand width and a
//           helper that sizes the iteration counter.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    // Counter counts WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
    function automatic int div_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_sub_stage.sv
`default_nettype none
// ============================================================================
// Module  : div_sub_stage
// Purpose : Combinational (WIDTH+1)-bit trial subtract, minuend - subtrahend,
//           built as a ripple chain of full-adder cells (add of complement,
//           carry in = 1).
// Ports   : minuend    (in)  WIDTH+1 bits
//           subtrahend (in)  WIDTH+1 bits
//           diff       (out) WIDTH+1 bits, modulo difference
//           borrow     (out) 1 when minuend < subtrahend (unsigned)
// Revision: 1.0  initial release
// ============================================================================
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           borrow
);
    logic [WIDTH+1:0] w_carry;
    logic [WIDTH:0]   w_sub_n;

    assign w_sub_n    = ~subtrahend;
    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
            fa u_fa (
                .a   (minuend[i]),
                .b   (w_sub_n[i]),
                .cin (w_carry[i]),
                .s   (diff[i]),
                .cout(w_carry[i+1])
            );
        end
    endgenerate

    // No carry out of an add-of-complement means the subtract borrowed.
    assign borrow = ~w_carry[WIDTH+1];
endmodule : div_sub_stage
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
// Module  : fa
// Purpose : Full-adder cell composed of two half-adder cells.
// Ports   : a, b, cin (in)  addend bits and carry in
//           s         (out) sum bit
//           cout      (out) carry out
// Revision: 1.0  initial release
// ============================================================================
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    ha u_ha0 (.a(a),    .b(b),   .s(w_s0), .c(w_c0));
    ha u_ha1 (.a(w_s0), .b(cin), .s(s),    .c(w_c1));

    assign cout = w_c0 | w_c1;
endmodule : fa
`default_nettype wire

// File: rtl/ha.sv
`default_nettype none
// ============================================================================
// Module  : ha
// Purpose : Half-adder cell.
// Ports   : a, b (in)  addend bits
//           s    (out) sum bit
//           c    (out) carry bit
// Revision: 1.0  initial release
// ============================================================================
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule : ha
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_restoring_divider
// Purpose : Iterative restoring divider, one quotient bit per clock, with a
//           start/busy/done handshake. Results are registered and only
//           change in the cycle done pulses.
// Ports   : clk       (in)  rising-edge clock
//           rst_n     (in)  synchronous active-low reset
//           start     (in)  launch request, accepted only in IDLE
//           dividend  (in)  WIDTH numerator
//           divisor   (in)  WIDTH denominator
//           busy      (out) operation in progress
//           done      (out) one-cycle result-valid pulse
//           quotient  (out) WIDTH result
//           remainder (out) WIDTH result
//           div_zero  (out) last division had divisor == 0
// Config  : DIVIDER_SIGNED_EN - two's complement operands, truncating
//           toward zero; remainder carries the dividend's sign.
// Revision: 1.0  initial release
// ============================================================================
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int                 c_cnt_w    = div_cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    div_state_t         r_state;
    div_state_t         w_next_state;

    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_zero;

    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_divisor_zero;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_q_load;
    logic [WIDTH:0]     w_a_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;
    logic               w_unused_acc_msb;

    // A start arriving alongside the done pulse is dropped.
    assign w_accept       = (r_state == IDLE) && start && !r_done;
    assign w_divisor_zero = (divisor == '0);

`ifdef DIVIDER_SIGNED_EN
    logic r_q_neg;
    logic r_r_neg;

    assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_q_final = r_q_neg ? -r_q : r_q;
    assign w_r_final = r_r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_final = r_q;
    assign w_r_final = r_acc[WIDTH-1:0];
`endif

    // Divide-by-zero skips RUN and reports the dividend untouched, so the raw
    // value is parked in Q instead of its magnitude.
    assign w_q_load = w_divisor_zero ? dividend : w_dvd_mag;

    // After every restore step A < D, so A's top bit is always zero and the
    // shifted partial remainder still fits in WIDTH+1 bits.
    assign w_a_shift        = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_unused_acc_msb = r_acc[WIDTH];

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .minuend   (w_a_shift),
        .subtrahend({1'b0, r_d}),
        .diff      (w_diff),
        .borrow    (w_borrow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_divisor_zero ? FIN : RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_next_state = FIN;
                end
            end
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc  <= '0;
                        r_q    <= w_q_load;
                        r_d    <= w_dvs_mag;
                        r_cnt  <= c_cnt_init;
                        r_zero <= w_divisor_zero;
`ifdef DIVIDER_SIGNED_EN
                        r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_r_neg <= dividend[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    r_acc <= w_borrow ? w_a_shift : w_diff;
                    r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
                end
                FIN: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_zero;
                    if (r_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_q;
                    end else begin
                        r_quotient  <= w_q_final;
                        r_remainder <= w_r_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule : seq_restoring_divider
`default_nettype wire
